conv_output_collector: RTL and testbench

Sink-side companion to the convolver's enable generator. Captures the convolver result stream qualified by the enable strobe, tags each valid result with its output-map row/column, and buffers it in a small FIFO. Presents results downstream on a valid/ready port. Sits between the convolver datapath and the output feature-map writer / next layer.

---
 rtl/conv_pkg.sv | 24 ++
 rtl/conv_tag_fifo.sv | 91 +++++++++
 rtl/conv_output_collector.sv | 126 ++++++++++++
 tb/tb_conv_output_collector.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolver output collector: output-map geometry,
// FIFO entry width and write-side FSM encoding.
package conv_pkg;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  function automatic int out_dim(input int image_size, input int kernel_size);
    return image_size - kernel_size + 1;
  endfunction

  // Tag counters need at least one bit even for a degenerate 1x1 output map.
  function automatic int row_w(input int image_size, input int kernel_size);
    int d;
    d = out_dim(image_size, kernel_size);
    return (d < 2) ? 1 : $clog2(d);
  endfunction

  // Entry layout, MSB first: {data, row, col, last}.
  function automatic int entry_w(input int data_width, input int tag_width);
    return data_width + 2 * tag_width + 1;
  endfunction

endpackage

// File: rtl/conv_tag_fifo.sv
// Synchronous FIFO whose head word lives in a dedicated output register, so the
// read port is registered and a push into an empty FIFO is visible after one edge.
module conv_tag_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    mem_cnt_q, mem_cnt_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] dout_q, dout_d;

  logic [CW-1:0] total;
  logic          pop;
  logic          push;
  logic          load_mem;
  logic          load_bypass;
  logic          mem_wr;

  // Capacity counts the output register, so DEPTH words are held in total.
  assign total = mem_cnt_q + CW'(valid_q);
  assign full  = (total == CW'(DEPTH));
  assign empty = ~valid_q;
  assign pop   = valid_q & rd_en;
  assign push  = wr_en & (~full | pop);

  always_comb begin
    dout_d      = dout_q;
    valid_d     = valid_q;
    rd_ptr_d    = rd_ptr_q;
    load_mem    = 1'b0;
    load_bypass = 1'b0;
    if (!valid_q || pop) begin
      if (mem_cnt_q != '0) begin
        dout_d   = mem[rd_ptr_q];
        valid_d  = 1'b1;
        rd_ptr_d = rd_ptr_q + 1'b1;
        load_mem = 1'b1;
      end else if (push) begin
        dout_d      = wr_data;
        valid_d     = 1'b1;
        load_bypass = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
    mem_wr    = push & ~load_bypass;
    wr_ptr_d  = mem_wr ? (wr_ptr_q + 1'b1) : wr_ptr_q;
    mem_cnt_d = mem_cnt_q + CW'(mem_wr) - CW'(load_mem);
  end

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      mem_cnt_q <= '0;
      valid_q   <= 1'b0;
      dout_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      mem_cnt_q <= mem_cnt_d;
      valid_q   <= valid_d;
      dout_q    <= dout_d;
    end
  end

  assign rd_data = dout_q;

endmodule

// File: rtl/conv_output_collector.sv
// Tags each enabled convolver result with its output-map (row, col) and buffers it
// for a valid/ready consumer. Optional macro RELU_EN clamps negative results to 0.
module conv_output_collector
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int IMAGE_SIZE  = 28,
  parameter int KERNEL_SIZE = 5,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         in_en,
  input  logic [DATA_WIDTH-1:0]                        in_data,
  output logic                                         m_valid,
  input  logic                                         m_ready,
  output logic [DATA_WIDTH-1:0]                        m_data,
  output logic [row_w(IMAGE_SIZE, KERNEL_SIZE)-1:0]    m_row,
  output logic [row_w(IMAGE_SIZE, KERNEL_SIZE)-1:0]    m_col,
  output logic                                         m_last,
  output logic                                         frame_done,
  output logic                                         busy,
  output logic                                         overflow
);

  localparam int OUT_DIM = out_dim(IMAGE_SIZE, KERNEL_SIZE);
  localparam int ROW_W   = row_w(IMAGE_SIZE, KERNEL_SIZE);
  localparam int ENTRY_W = entry_w(DATA_WIDTH, ROW_W);
  localparam logic [ROW_W-1:0] LAST_IDX = ROW_W'(OUT_DIM - 1);

  logic [0:0]      state_q, state_d;
  logic [ROW_W-1:0] wr_row_q, wr_row_d;
  logic [ROW_W-1:0] wr_col_q, wr_col_d;
  logic            overflow_q, overflow_d;
  logic            frame_done_q, frame_done_d;

  logic [DATA_WIDTH-1:0] store_data;
  logic [ENTRY_W-1:0]    wr_entry;
  logic [ENTRY_W-1:0]    rd_entry;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  at_last;
  logic                  col_wrap;
  logic                  pop;
  logic                  drop;

`ifdef RELU_EN
  assign store_data = in_data[DATA_WIDTH-1] ? '0 : in_data;
`else
  assign store_data = in_data;
`endif

  assign col_wrap = (wr_col_q == LAST_IDX);
  assign at_last  = (wr_row_q == LAST_IDX) && col_wrap;
  assign wr_entry = {store_data, wr_row_q, wr_col_q, at_last};

  assign m_valid = ~fifo_empty;
  assign pop     = m_valid & m_ready;
  // A push into a full FIFO survives only when the head leaves on the same edge.
  assign drop    = in_en & fifo_full & ~pop;

  conv_tag_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (in_en),
    .wr_data (wr_entry),
    .rd_en   (m_ready),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign {m_data, m_row, m_col, m_last} = rd_entry;

  // Counters advance on every strobe, dropped or not, to keep tags frame-aligned.
  always_comb begin
    wr_row_d = wr_row_q;
    wr_col_d = wr_col_q;
    if (in_en) begin
      if (col_wrap) begin
        wr_col_d = '0;
        wr_row_d = (wr_row_q == LAST_IDX) ? '0 : (wr_row_q + 1'b1);
      end else begin
        wr_col_d = wr_col_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (in_en && !at_last) state_d = ST_ACTIVE;
      ST_ACTIVE: if (in_en && at_last)  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    overflow_d   = overflow_q | drop;
    frame_done_d = pop & m_last;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      wr_row_q     <= '0;
      wr_col_q     <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_row_q     <= wr_row_d;
      wr_col_q     <= wr_col_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign busy       = (state_q == ST_ACTIVE) | in_en;
  assign overflow   = overflow_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_output_collector.sv
// Scoreboard bench for conv_output_collector: a model process queues expected
// entries as strobes are issued, a monitor compares every word the DUT presents.
module tb_conv_output_collector;

  localparam int DEPTH = 8;
`ifdef RELU_EN
  localparam logic [15:0] EXP_NEG = 16'h0000;
`else
  localparam logic [15:0] EXP_NEG = 16'hFFF6;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_en = 1'b0;
  logic [15:0] in_data = 16'h0;
  logic        m_ready = 1'b0;
  logic        m_valid;
  logic [15:0] m_data;
  logic [4:0]  m_row;
  logic [4:0]  m_col;
  logic        m_last;
  logic        frame_done;
  logic        busy;
  logic        overflow;

  always #5 clk = ~clk;

  conv_output_collector dut (
    .clk        (clk),
    .reset      (reset),
    .in_en      (in_en),
    .in_data    (in_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_row      (m_row),
    .m_col      (m_col),
    .m_last     (m_last),
    .frame_done (frame_done),
    .busy       (busy),
    .overflow   (overflow)
  );

  typedef struct packed {
    logic [15:0] d;
    logic [4:0]  r;
    logic [4:0]  c;
    logic        l;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  int          occ = 0;
  logic [4:0]  mrow = 5'd0;
  logic [4:0]  mcol = 5'd0;
  logic        exp_ovf = 1'b0;
  logic        fd_exp = 1'b0;
  int          out_cnt = 0;
  int          fd_cnt = 0;
  int          last_cnt = 0;
  logic [15:0] out_data [1200];
  logic [4:0]  out_row  [1200];
  logic [4:0]  out_col  [1200];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] relu(input logic [15:0] d);
`ifdef RELU_EN
    return d[15] ? 16'h0000 : d;
`else
    return d;
`endif
  endfunction

  // Model: occupancy, tag counters and overflow, updated once per cycle.
  always @(negedge clk) begin : model
    logic pop_m;
    logic acc;
    exp_t e_new;
    if (reset) begin
      occ     = 0;
      mrow    = 5'd0;
      mcol    = 5'd0;
      exp_ovf = 1'b0;
    end else begin
      chk("m_valid", 32'(m_valid), 32'(occ > 0));
      chk("overflow", 32'(overflow), 32'(exp_ovf));
      pop_m = (occ > 0) && m_ready;
      acc   = 1'b0;
      if (in_en) begin
        if (occ < DEPTH || pop_m) begin
          e_new = '{relu(in_data), mrow, mcol, (mrow == 5'd23 && mcol == 5'd23)};
          exp_q.push_back(e_new);
          acc = 1'b1;
        end else begin
          exp_ovf = 1'b1;
        end
        if (mcol == 5'd23) begin
          mcol = 5'd0;
          mrow = (mrow == 5'd23) ? 5'd0 : mrow + 5'd1;
        end else begin
          mcol = mcol + 5'd1;
        end
      end
      occ = occ - int'(pop_m) + int'(acc);
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset) begin
      fd_exp = 1'b0;
    end else begin
      chk("frame_done", 32'(frame_done), 32'(fd_exp));
      fd_exp = 1'b0;
      if (frame_done) fd_cnt++;
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got data %0h, expected no output", m_data);
        end else begin
          e = exp_q[0];
          chk("out_word", 32'({m_data, m_row, m_col, m_last}), 32'(e));
          if (m_ready) begin
            void'(exp_q.pop_front());
            if (out_cnt < 1200) begin
              out_data[out_cnt] = m_data;
              out_row[out_cnt]  = m_row;
              out_col[out_cnt]  = m_col;
            end
            $display("[TB] pop %0d data=%h tag=(%0d,%0d) last=%0b", out_cnt, m_data, m_row, m_col, m_last);
            out_cnt++;
            if (m_last) last_cnt++;
            if (e.l) fd_exp = 1'b1;
          end
        end
      end
    end
  end

  task automatic cyc(input logic en, input logic [15:0] d, input logic rdy);
    @(posedge clk);
    #1;
    in_en   = en;
    in_data = d;
    m_ready = rdy;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset   = 1'b1;
    in_en   = 1'b0;
    in_data = 16'h0;
    m_ready = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    out_cnt  = 0;
    fd_cnt   = 0;
    last_cnt = 0;
    reset    = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && (exp_q.size() != 0 || m_valid); i++) cyc(1'b0, 16'h0, 1'b1);
    chk("drain_done", 32'(exp_q.size()), 32'd0);
    repeat (2) cyc(1'b0, 16'h0, 1'b1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    // Reset values
    @(posedge clk);
    #2;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_m_row", 32'(m_row), 32'd0);
    chk("rst_m_col", 32'(m_col), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // One full frame, always ready
    for (int k = 0; k < 576; k++) begin
      cyc(1'b1, 16'(k), 1'b1);
      if (k == 0 || k == 300) begin
        #1;
        chk("busy_in_frame", 32'(busy), 32'd1);
      end
    end
    cyc(1'b0, 16'h0, 1'b1);
    drain();
    chk("f1_count", 32'(out_cnt), 32'd576);
    chk("f1_last_count", 32'(last_cnt), 32'd1);
    chk("f1_frame_done_count", 32'(fd_cnt), 32'd1);
    chk("f1_tag0", 32'({out_row[0], out_col[0]}), 32'({5'd0, 5'd0}));
    chk("f1_tag23", 32'({out_row[23], out_col[23]}), 32'({5'd0, 5'd23}));
    chk("f1_tag24", 32'({out_row[24], out_col[24]}), 32'({5'd1, 5'd0}));
    chk("f1_data575", 32'(out_data[575]), 32'd575);
    chk("f1_busy_after", 32'(busy), 32'd0);

    // Overflow: 10 pushes into 8 entries with no reader
    do_reset();
    for (int k = 0; k < 10; k++) cyc(1'b1, 16'(k), 1'b0);
    cyc(1'b0, 16'h0, 1'b0);
    #1;
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_head", 32'(m_data), 32'd0);
    drain();
    chk("ovf_count", 32'(out_cnt), 32'd8);
    chk("ovf_data7", 32'(out_data[7]), 32'd7);
    cyc(1'b1, 16'd10, 1'b1);
    cyc(1'b0, 16'h0, 1'b1);
    drain();
    chk("ovf_count_after", 32'(out_cnt), 32'd9);
    chk("ovf_data10", 32'(out_data[8]), 32'd10);
    chk("ovf_tag10", 32'({out_row[8], out_col[8]}), 32'({5'd0, 5'd10}));
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Full FIFO, push and pop on the same edge
    do_reset();
    for (int k = 0; k < 8; k++) cyc(1'b1, 16'(k), 1'b0);
    cyc(1'b1, 16'd8, 1'b1);
    cyc(1'b0, 16'h0, 1'b1);
    drain();
    chk("full_pop_overflow", 32'(overflow), 32'd0);
    chk("full_pop_count", 32'(out_cnt), 32'd9);
    chk("full_pop_data8", 32'(out_data[8]), 32'd8);
    chk("full_pop_tag8", 32'({out_row[8], out_col[8]}), 32'({5'd0, 5'd8}));

    // Two frames back-to-back
    do_reset();
    for (int k = 0; k < 1152; k++) cyc(1'b1, 16'(k), 1'b1);
    cyc(1'b0, 16'h0, 1'b1);
    drain();
    chk("f2_count", 32'(out_cnt), 32'd1152);
    chk("f2_frame_done_count", 32'(fd_cnt), 32'd2);
    chk("f2_last_count", 32'(last_cnt), 32'd2);
    chk("f2_tag575", 32'({out_row[575], out_col[575]}), 32'({5'd23, 5'd23}));
    chk("f2_tag576", 32'({out_row[576], out_col[576]}), 32'({5'd0, 5'd0}));
    chk("f2_data576", 32'(out_data[576]), 32'd576);

    // Reset mid-frame
    do_reset();
    for (int k = 0; k < 100; k++) cyc(1'b1, 16'(1000 + k), (k < 60));
    cyc(1'b0, 16'h0, 1'b0);
    #1;
    chk("mid_valid", 32'(m_valid), 32'd1);
    chk("mid_head_data", 32'(m_data), 32'd1059);
    chk("mid_head_tag", 32'({m_row, m_col}), 32'({5'd2, 5'd11}));
    @(posedge clk);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("arst_m_valid", 32'(m_valid), 32'd0);
    chk("arst_m_data", 32'(m_data), 32'd0);
    chk("arst_tag", 32'({m_row, m_col, m_last}), 32'd0);
    chk("arst_overflow", 32'(overflow), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    out_cnt  = 0;
    fd_cnt   = 0;
    last_cnt = 0;
    reset    = 1'b0;
    cyc(1'b1, 16'd55, 1'b1);
    cyc(1'b0, 16'h0, 1'b1);
    drain();
    chk("post_rst_count", 32'(out_cnt), 32'd1);
    chk("post_rst_data", 32'(out_data[0]), 32'd55);
    chk("post_rst_tag", 32'({out_row[0], out_col[0]}), 32'({5'd0, 5'd0}));

    // Negative and positive results
    do_reset();
    cyc(1'b1, 16'hFFF6, 1'b1);
    cyc(1'b1, 16'h0007, 1'b1);
    cyc(1'b0, 16'h0, 1'b1);
    drain();
    chk("relu_neg", 32'(out_data[0]), 32'(EXP_NEG));
    chk("relu_pos", 32'(out_data[1]), 32'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
